// File: rtl/tl_pkg.sv
// Shared types for the TLP header generator.
//   tl_cmd_type_e : command class (only MEM and CFG are supported)
//   tl_cmd_t      : per-channel user command
//   FMT_TYPE_*    : combined Fmt[2:0]/Type[4:0] byte placed in DW0[31:24]
package tl_pkg;

    localparam int TL_LEN_W = 10;

    typedef enum logic [1:0] {
        CMD_MEM = 2'd0,
        CMD_CFG = 2'd1,
        CMD_IO  = 2'd2,
        CMD_MSG = 2'd3
    } tl_cmd_type_e;

    typedef struct packed {
        tl_cmd_type_e          cmd_type;
        logic                  wr_en;
        logic [63:0]           addr;
        logic [TL_LEN_W-1:0]   len;
        logic [7:0]            bus;
        logic [4:0]            device;
        logic [2:0]            function_num;
        logic [9:0]            reg_num;
    } tl_cmd_t;

    localparam logic [7:0] FMT_TYPE_MRD32  = 8'h00;
    localparam logic [7:0] FMT_TYPE_MRD64  = 8'h20;
    localparam logic [7:0] FMT_TYPE_MWR32  = 8'h40;
    localparam logic [7:0] FMT_TYPE_MWR64  = 8'h60;
    localparam logic [7:0] FMT_TYPE_CFGRD0 = 8'h04;
    localparam logic [7:0] FMT_TYPE_CFGWR0 = 8'h44;

endpackage

// File: rtl/tl_rr_arb.sv
// Round-robin arbiter.
//   req     : request vector
//   advance : move pointer past the current winner
//   grant   : one-hot winner (first request at or after the pointer)
//   idx     : binary index of the winner
module tl_rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    int            sel;

    // Scan from farthest to nearest so the channel closest to the pointer wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        sel   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            sel = int'(ptr) + k;
            if (sel >= N) sel = sel - N;
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                idx        = IW'(sel);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/tl_hdr_gen_mc.sv
// Multi-channel TLP header generator.
// Arbitrates NUM_CH command channels, then builds one 3DW/4DW MRd/MWr/CfgRd0/CfgWr0
// header at a time once the needed credit (and tag for non-posted) is present.
//   cmd_i/cmd_valid_i/cmd_ready_o : per-channel command, one-hot accept in IDLE
//   tag_*                         : tag table handshake (non-posted only)
//   *_credit_*                    : posted / non-posted credit check and consume
//   hdr_*                         : held valid/ready header stream
//   err_*                         : pulse for dropped unsupported commands
module tl_hdr_gen_mc
    import tl_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int TAG_W  = 8,
    parameter  int LEN_W  = TL_LEN_W,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             REQUESTER_ID,
    input  tl_cmd_t [NUM_CH-1:0]    cmd_i,
    input  logic [NUM_CH-1:0]       cmd_valid_i,
    output logic [NUM_CH-1:0]       cmd_ready_o,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic                    tag_valid_i,
    output logic                    tag_consume_o,
    input  logic                    p_credit_ok_i,
    input  logic                    np_credit_ok_i,
    output logic                    p_credit_consume_o,
    output logic                    np_credit_consume_o,
    output logic [127:0]            hdr_o,
    output logic                    hdr_4dw_o,
    output logic [CH_W-1:0]         hdr_ch_o,
    output logic                    is_posted_o,
    output logic                    hdr_valid_o,
    input  logic                    hdr_ready_i,
    output logic                    err_valid_o,
    output logic [CH_W-1:0]         err_ch_o
);

    typedef enum logic [1:0] {IDLE, BUILD, SEND} state_e;

    state_e          state, state_nx;
    tl_cmd_t         cmd_q;
    logic [CH_W-1:0] ch_q;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0] gidx;
    logic            accept, load, is_mem, is_cfg, posted;

    function automatic logic [127:0] pack_hdr(input tl_cmd_t c, input logic [7:0] tag,
                                              input logic [15:0] rid);
        logic [127:0] h;
        logic         four;
        h    = '0;
        four = |c.addr[63:32];
        h[95:80] = rid;
        h[79:72] = tag;
        if (c.cmd_type == CMD_MEM) begin
            if (c.wr_en) h[127:120] = four ? FMT_TYPE_MWR64 : FMT_TYPE_MWR32;
            else         h[127:120] = four ? FMT_TYPE_MRD64 : FMT_TYPE_MRD32;
            h[105:96] = 10'(c.len[LEN_W-1:0]);
            h[71:68]  = (c.len == LEN_W'(1)) ? 4'b0000 : 4'b1111;
            h[67:64]  = 4'b1111 << c.addr[1:0];
            if (four) begin
                h[63:32] = c.addr[63:32];
                h[31:2]  = c.addr[31:2];
            end else begin
                h[63:34] = c.addr[31:2];
            end
        end else begin
            h[127:120] = c.wr_en ? FMT_TYPE_CFGWR0 : FMT_TYPE_CFGRD0;
            h[105:96]  = 10'd1;
            h[67:64]   = 4'b1111;
            h[63:56]   = c.bus;
            h[55:51]   = c.device;
            h[50:48]   = c.function_num;
            h[43:34]   = c.reg_num;
        end
        return h;
    endfunction

    tl_rr_arb #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (cmd_valid_i),
        .advance (accept),
        .grant   (grant),
        .idx     (gidx)
    );

    assign accept      = (state == IDLE) && |cmd_valid_i;
    assign cmd_ready_o = (state == IDLE) ? grant : '0;
    assign is_mem      = (cmd_q.cmd_type == CMD_MEM);
    assign is_cfg      = (cmd_q.cmd_type == CMD_CFG);
    assign posted      = is_mem && cmd_q.wr_en;
    assign hdr_valid_o = (state == SEND);
    assign err_ch_o    = err_valid_o ? ch_q : '0;

    always_comb begin
        state_nx            = state;
        load                = 1'b0;
        err_valid_o         = 1'b0;
        tag_consume_o       = 1'b0;
        p_credit_consume_o  = 1'b0;
        np_credit_consume_o = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = BUILD;
            BUILD: begin
                if (!is_mem && !is_cfg) begin
                    err_valid_o = 1'b1;
                    state_nx    = IDLE;
                end else if (posted) begin
                    if (p_credit_ok_i) begin
                        load               = 1'b1;
                        p_credit_consume_o = 1'b1;
                        state_nx           = SEND;
                    end
                end else if (np_credit_ok_i && tag_valid_i) begin
                    load                = 1'b1;
                    np_credit_consume_o = 1'b1;
                    tag_consume_o       = 1'b1;
                    state_nx            = SEND;
                end
            end
            SEND:    if (hdr_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            ch_q        <= '0;
            hdr_o       <= '0;
            hdr_4dw_o   <= 1'b0;
            hdr_ch_o    <= '0;
            is_posted_o <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cmd_q <= cmd_i[gidx];
                ch_q  <= gidx;
            end
            // Output fields only change here, so they stay frozen through SEND.
            if (load) begin
                hdr_o       <= pack_hdr(cmd_q, posted ? 8'h00 : 8'(tag_i), REQUESTER_ID);
                hdr_4dw_o   <= is_mem && |cmd_q.addr[63:32];
                hdr_ch_o    <= ch_q;
                is_posted_o <= posted;
            end
        end
    end

endmodule
